// File: rtl/array_feeder.sv
// Systolic-array input sequencer: loads an NxN weight tile, bursts it down the PE chain, strobes switch, then streams activations.
// Define ARRAY_FEEDER_SKEW_EN for the triangular activation skew line and the DRAIN phase.
module array_feeder #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           w_valid,
    output logic           w_ready,
    input  logic [N*W-1:0] w_data,
    input  logic           a_valid,
    output logic           a_ready,
    input  logic [N*W-1:0] a_data,
    input  logic           a_last,
    output logic [N*W-1:0] b_out,
    output logic           switch_out,
    output logic [N*W-1:0] a_out,
    output logic [N-1:0]   a_vld_out,
    output logic           busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(N - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_SHIFT_W,
        S_SWITCH,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_nextCnt;
    logic [CW-1:0]  w_shiftIdx;
    logic [N*W-1:0] r_wbuf [N];
    logic [N*W-1:0] r_bOut;
    logic [N*W-1:0] w_nextBOut;
    logic           r_switch;
    logic           w_nextSwitch;
    logic           w_wFire;
    logic           w_aFire;

    assign w_wFire = w_ready & w_valid;
    assign w_aFire = a_ready & a_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // b_out is registered, so the last beat is forwarded straight from w_data to open the burst one cycle after acceptance.
    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = r_cnt;
        w_nextBOut   = '0;
        w_nextSwitch = 1'b0;
        w_ready      = 1'b0;
        a_ready      = 1'b0;
        busy         = (r_state != S_IDLE);
        w_shiftIdx   = CNT_LAST - r_cnt - CW'(1);
        unique case (r_state)
            S_IDLE, S_LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    if (r_cnt == CNT_LAST) begin
                        w_nextCnt   = '0;
                        w_nextState = S_SHIFT_W;
                        w_nextBOut  = w_data;
                    end else begin
                        w_nextCnt   = r_cnt + CW'(1);
                        w_nextState = S_LOAD_W;
                    end
                end
            end
            S_SHIFT_W: begin
                if (r_cnt == CNT_LAST) begin
                    w_nextCnt    = '0;
                    w_nextState  = S_SWITCH;
                    w_nextSwitch = 1'b1;
                end else begin
                    w_nextCnt  = r_cnt + CW'(1);
                    w_nextBOut = r_wbuf[w_shiftIdx];
                end
            end
            S_SWITCH: begin
                w_nextState = S_STREAM;
            end
            S_STREAM: begin
                a_ready = 1'b1;
                if (a_valid && a_last) begin
`ifdef ARRAY_FEEDER_SKEW_EN
                    w_nextState = S_DRAIN;
`else
                    w_nextState = S_IDLE;
`endif
                end
            end
            S_DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_nextCnt   = '0;
                    w_nextState = S_IDLE;
                end else begin
                    w_nextCnt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_nextState = S_IDLE;
                w_nextCnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_bOut   <= '0;
            r_switch <= 1'b0;
            for (int k = 0; k < N; k++) begin
                r_wbuf[k] <= '0;
            end
        end else begin
            r_cnt    <= w_nextCnt;
            r_bOut   <= w_nextBOut;
            r_switch <= w_nextSwitch;
            if (w_wFire) begin
                r_wbuf[r_cnt] <= w_data;
            end
        end
    end

    assign b_out      = r_bOut;
    assign switch_out = r_switch;

    // A cycle without an accepted vector pushes a zero, invalid bubble into every lane.
    for (genvar i = 0; i < N; i++) begin : g_lane
`ifdef ARRAY_FEEDER_SKEW_EN
        localparam int DEPTH = i + 1;
`else
        localparam int DEPTH = 1;
`endif
        logic [W-1:0] r_data [DEPTH];
        logic         r_vld  [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j < DEPTH; j++) begin
                    r_data[j] <= '0;
                    r_vld[j]  <= 1'b0;
                end
            end else begin
                r_data[0] <= w_aFire ? a_data[i*W +: W] : '0;
                r_vld[0]  <= w_aFire;
                for (int j = DEPTH - 1; j > 0; j--) begin
                    r_data[j] <= r_data[j-1];
                    r_vld[j]  <= r_vld[j-1];
                end
            end
        end

        assign a_out[i*W +: W] = r_data[DEPTH-1];
        assign a_vld_out[i]    = r_vld[DEPTH-1];
    end

endmodule

// File: tb/tb_array_feeder.sv
// Scoreboard bench for array_feeder: directed loads/streams push expectations, a negedge monitor pops and compares.
module tb_array_feeder;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int WIDE = N * W;
`ifdef ARRAY_FEEDER_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif
    localparam int DRAINC = SKEW ? N - 1 : 0;
    localparam logic [WIDE-1:0] JUNK = {N{32'hDEADBEEF}};

    logic            clk;
    logic            rst_n;
    logic            w_valid;
    logic            w_ready;
    logic [WIDE-1:0] w_data;
    logic            a_valid;
    logic            a_ready;
    logic [WIDE-1:0] a_data;
    logic            a_last;
    logic [WIDE-1:0] b_out;
    logic            switch_out;
    logic [WIDE-1:0] a_out;
    logic [N-1:0]    a_vld_out;
    logic            busy;

    typedef struct {
        int              cyc;
        logic            busy;
        logic            wr;
        logic            ar;
        logic            sw;
        logic [WIDE-1:0] b;
    } snap_t;

    typedef struct {
        int           cyc;
        int           lane;
        logic [W-1:0] data;
    } lane_t;

    typedef struct {
        int                       cyc;
        logic [N-1:0][WIDE-1:0]   rows;
    } sw_t;

    snap_t qSnap[$];
    lane_t qLane[$];
    sw_t   qSw[$];

    logic [WIDE-1:0] bHist [1:N+1] = '{default: '0};
    int edgeCnt = 0;
    int checks  = 0;
    int errors  = 0;

    array_feeder #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_data     (a_data),
        .a_last     (a_last),
        .b_out      (b_out),
        .switch_out (switch_out),
        .a_out      (a_out),
        .a_vld_out  (a_vld_out),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    function automatic int curCycle();
        return edgeCnt + 1;
    endfunction

    function automatic logic [WIDE-1:0] mkRow(input int base);
        logic [WIDE-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) v[j*W +: W] = W'(base + j);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [WIDE-1:0] actual, input logic [WIDE-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, curCycle());
        end
    endtask

    task automatic noteFail(input string name, input string what);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s (cycle %0d)", name, what, curCycle());
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic pushSnap(input int cyc, input logic bsy, input logic wr, input logic ar, input logic sw,
                            input logic [WIDE-1:0] b);
        qSnap.push_back('{cyc, bsy, wr, ar, sw, b});
    endtask

    // Presents one weight row per cycle (optionally with an idle gap between rows); returns in the first burst cycle.
    task automatic loadTile(input logic [N-1:0][WIDE-1:0] rows, input bit gaps, input bit expectSwitch);
        int t;
        t = 0;
        for (int r = 0; r < N; r++) begin
            w_valid = 1'b1;
            w_data  = rows[r];
            pushSnap(curCycle(), r != 0, 1'b1, 1'b0, 1'b0, '0);
            t = curCycle();
            waitEdge();
            if (gaps && r != N - 1) begin
                w_valid = 1'b0;
                w_data  = JUNK;
                pushSnap(curCycle(), 1'b1, 1'b1, 1'b0, 1'b0, '0);
                waitEdge();
            end
        end
        w_valid = 1'b0;
        w_data  = JUNK;
        pushSnap(curCycle(), 1'b1, 1'b0, 1'b0, 1'b0, rows[N-1]);
        if (expectSwitch) qSw.push_back('{t + N + 1, rows});
    endtask

    task automatic sendVector(input logic [WIDE-1:0] v, input logic last);
        int s;
        a_valid = 1'b1;
        a_data  = v;
        a_last  = last;
        s = curCycle();
        pushSnap(s, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < N; i++) qLane.push_back('{SKEW ? s + 1 + i : s + 1, i, v[i*W +: W]});
        if (last) begin
            if (SKEW) pushSnap(s + N - 1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
            pushSnap(s + DRAINC + 1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        end
        waitEdge();
        a_valid = 1'b0;
        a_last  = 1'b0;
        a_data  = JUNK;
    endtask

    task automatic bubble();
        pushSnap(curCycle(), 1'b1, 1'b0, 1'b1, 1'b0, '0);
        waitEdge();
    endtask

    task automatic applyStimulus();
        logic [N-1:0][WIDE-1:0] rowsA, rowsB, rowsC, rowsD;
        for (int r = 0; r < N; r++) begin
            rowsA[r] = mkRow(16 * r);
            rowsB[r] = mkRow(256 + 16 * r);
            rowsC[r] = mkRow(512 + 16 * r);
            rowsD[r] = mkRow(768 + 16 * r);
        end

        rst_n   = 1'b0;
        w_valid = 1'b0;
        w_data  = '0;
        a_valid = 1'b0;
        a_data  = '0;
        a_last  = 1'b0;
        waitEdge();
        pushSnap(curCycle(), 1'b0, 1'b1, 1'b0, 1'b0, '0);
        waitEdge();
        waitEdge();
        rst_n = 1'b1;

        $display("[TB] tile A: back-to-back load, early-held vector, two-vector pass");
        loadTile(rowsA, 1'b0, 1'b1);
        a_valid = 1'b1;
        a_data  = mkRow(1);
        repeat (N + 1) waitEdge();
        sendVector(mkRow(1), 1'b0);
        sendVector(mkRow(5), 1'b1);
        repeat (DRAINC) waitEdge();

        $display("[TB] tile B: gapped load, bubble between vectors");
        loadTile(rowsB, 1'b1, 1'b1);
        repeat (N + 1) waitEdge();
        sendVector(mkRow(9), 1'b0);
        bubble();
        sendVector(mkRow(13), 1'b1);
        repeat (DRAINC) waitEdge();

        $display("[TB] tile C aborted by reset at burst step 2, then tile D");
        loadTile(rowsC, 1'b0, 1'b0);
        waitEdge();
        waitEdge();
        #2;
        rst_n = 1'b0;
        pushSnap(curCycle(), 1'b0, 1'b1, 1'b0, 1'b0, '0);
        waitEdge();
        rst_n = 1'b1;
        loadTile(rowsD, 1'b0, 1'b1);
        repeat (N + 1) waitEdge();
        sendVector(mkRow(17), 1'b1);
        repeat (DRAINC) waitEdge();
        repeat (2 * N + 2) waitEdge();
    endtask

    task automatic monitorStep();
        int    cur;
        bit    found;
        snap_t se;
        sw_t   we;
        cur = curCycle();

        while (qSnap.size() > 0 && qSnap[0].cyc <= cur) begin
            se = qSnap.pop_front();
            if (se.cyc < cur) begin
                noteFail("snapshot", $sformatf("expectation for cycle %0d never sampled", se.cyc));
            end else begin
                checkOutput("busy", WIDE'(busy), WIDE'(se.busy));
                checkOutput("w_ready", WIDE'(w_ready), WIDE'(se.wr));
                checkOutput("a_ready", WIDE'(a_ready), WIDE'(se.ar));
                checkOutput("switch_out", WIDE'(switch_out), WIDE'(se.sw));
                checkOutput("b_out", b_out, se.b);
            end
        end

        if (switch_out) begin
            if (qSw.size() == 0) begin
                noteFail("switch_unexpected", "switch_out high with no burst pending");
            end else begin
                we = qSw.pop_front();
                checkOutput("switch_cycle", WIDE'(cur), WIDE'(we.cyc));
                checkOutput("b_out_in_switch", b_out, '0);
                for (int k = 1; k <= N; k++) begin
                    checkOutput($sformatf("burst_row_%0d", k - 1), bHist[k], we.rows[k-1]);
                end
                checkOutput("b_out_before_burst", bHist[N+1], '0);
            end
        end

        for (int i = 0; i < N; i++) begin
            if (a_vld_out[i]) begin
                found = 1'b0;
                for (int k = 0; k < qLane.size(); k++) begin
                    if (!found && qLane[k].lane == i) begin
                        checkOutput($sformatf("lane%0d_cycle", i), WIDE'(cur), WIDE'(qLane[k].cyc));
                        checkOutput($sformatf("lane%0d_data", i), WIDE'(a_out[i*W +: W]), WIDE'(qLane[k].data));
                        qLane.delete(k);
                        found = 1'b1;
                    end
                end
                if (!found) noteFail($sformatf("lane%0d_unexpected", i), "valid with no vector pending");
            end else begin
                checkOutput($sformatf("lane%0d_bubble", i), WIDE'(a_out[i*W +: W]), '0);
            end
        end

        for (int k = N + 1; k > 1; k--) bHist[k] = bHist[k-1];
        bHist[1] = b_out;
    endtask

    always @(negedge clk) monitorStep();

    initial begin
        applyStimulus();
        foreach (qSnap[k]) noteFail("snapshot_left", $sformatf("cycle %0d not checked", qSnap[k].cyc));
        foreach (qLane[k]) noteFail("lane_left", $sformatf("lane %0d due cycle %0d never valid", qLane[k].lane, qLane[k].cyc));
        foreach (qSw[k]) noteFail("switch_left", $sformatf("switch due cycle %0d never seen", qSw[k].cyc));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/array_feeder.md
# array_feeder

Input sequencer for the systolic array of processing elements. It collects an N×N weight tile and bursts it down the weight-propagation chain on N back-to-back cycles, then pulses the shared `switch` so every PE moves its dormant weight to active. It then streams activation vectors into the array's left edge with triangular skew, so each PE row sees its operand on the correct cycle. It sits directly upstream of the PE grid: `b_out` drives the top row's `b` inputs, `a_out` drives the left column's `a` inputs, and `switch_out` drives every PE's `switch`.

## Interface
- `N`, 4, array dimension (rows = columns = lanes)
- `W`, 32, data width per lane
- `clk` in 1: single clock, all state updates on the rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `w_valid` in 1: weight-row beat valid
- `w_ready` out 1: weight-row beat accepted when high with `w_valid`
- `w_data` in N*W: one weight row; lane j (bits j*W +: W) is column j
- `a_valid` in 1: activation vector valid
- `a_ready` out 1: activation vector accepted when high with `a_valid`
- `a_data` in N*W: one activation vector; lane i is PE row i
- `a_last` in 1: marks the final vector of the current tile pass
- `b_out` out N*W: top-row weight inputs of the array
- `switch_out` out 1: dormant-to-active strobe to all PEs
- `a_out` out N*W: skewed activation lanes to the left column
- `a_vld_out` out N: per-lane valid, skewed identically to `a_out`
- `busy` out 1: high in every state except IDLE

## Operation
- States: IDLE, LOAD_W, SHIFT_W, SWITCH, STREAM, DRAIN.
- IDLE / LOAD_W:
  - `w_ready`=1.
  - Each accepted beat is written to `wbuf[cnt]`, and `cnt` increments.
  - The first beat moves IDLE to LOAD_W.
  - When the Nth beat is accepted, `cnt` clears and the FSM goes to SHIFT_W.
- SHIFT_W: runs for exactly N cycles, k = 0..N-1, with `b_out` = `wbuf[N-1-k]`.
  - The last row goes first, so after the burst PE row r's dormant register holds weight row r.
  - `w_ready`=0 and `a_ready`=0.
  - A burst is never interrupted.
- SWITCH: one cycle with `switch_out`=1 and `b_out`=0, then go to STREAM.
- STREAM:
  - `a_ready`=1. Each accepted vector enters the skew line.
  - A cycle with no accepted vector inserts a bubble: zero data, valid 0.
  - Accepting a vector with `a_last`=1 moves the FSM to DRAIN.
- DRAIN:
  - `a_ready`=0. Zeros are pushed into the skew line for N-1 cycles, then the FSM goes to IDLE.
- Skew line:
  - Lane i passes through i+1 register stages.
  - Lane 0 has a single output register; lane N-1 has N stages.
  - Data and valid travel together.
- Arithmetic and width rules:
  - Data are passed through unmodified at width W; there is no arithmetic.
  - `cnt` is clog2(N) bits and wraps only by explicit clear.
- Reset:
  - Asserting `rst_n` low at any time, including mid-burst or mid-stream, forces IDLE immediately.
  - It clears `cnt`, `wbuf`, and all skew stages.
  - A partially loaded tile is discarded; a partially streamed pass is abandoned.
- Reset values: `b_out`=0, `switch_out`=0, `a_out`=0, `a_vld_out`=0, `busy`=0, `w_ready`=1, `a_ready`=0.

## Timing
- `w_ready`, `a_ready` and `busy` are decoded combinationally from the state; all other outputs are registered.
- Last weight beat accepted at edge t:
  - `b_out` carries `wbuf[N-1]` in cycle t+1, and `wbuf[0]` in cycle t+N.
  - `switch_out` is high in cycle t+N+1.
- The PE takes `active` from the dormant value that was captured in cycle t+N, before the SWITCH-cycle overwrite.
- Activation vector accepted at edge s: lane i appears on `a_out`/`a_vld_out[i]` in cycle s+1+i.
- `a_last` accepted at edge s:
  - The final lane (N-1) is valid in cycle s+N.
  - `busy` falls after DRAIN ends, so it is low from cycle s+N.
- A new weight beat can be accepted in the first IDLE cycle. Minimum turnaround between passes is N-1 drain cycles plus N+N+1 load cycles.
- Beats offered in states where `w_ready`/`a_ready` is 0 are held by the source; no loss and no duplication.

## Configuration
- `ARRAY_FEEDER_SKEW_EN` defined:
  - Skew line as above.
  - DRAIN lasts N-1 cycles.
- Undefined:
  - Every lane has a single register stage, so all lanes appear in cycle s+1.
  - DRAIN is skipped and the FSM goes from STREAM straight to IDLE after `a_last`.
  - Skew becomes the responsibility of the consumer.

## Test plan
- Reset state: hold `rst_n` low with N=4, W=32 → all outputs at their reset values, `w_ready`=1, `busy`=0.
- Weight load: 4 beats with rows r filled with 0x10*r+j → `b_out` shows rows 3,2,1,0 on 4 consecutive cycles, `switch_out` pulses once the next cycle, `b_out`=0 during the pulse.
- Weight backpressure: `w_valid` toggling every other cycle → `wbuf` holds exactly 4 rows, and the burst is still 4 contiguous cycles.
- Skew, with the macro: vectors {1,2,3,4} then {5,6,7,8} (`a_last` on the second), accepted at s and s+1:
  - `a_out` lane 0 = 1 at s+1, lane 3 = 4 at s+4, lane 3 = 8 at s+5.
  - `a_vld_out` matches those cycles, and `busy` is low at s+5.
- Bubble: one idle cycle between two vectors → a zero, invalid slot propagates diagonally across all lanes.
- Mid-burst reset: assert `rst_n` low at SHIFT_W k=2 → outputs clear immediately. A new 4-beat load afterwards produces a clean burst of the new data only.
